sort_result_streamer: RTL and testbench
=======================================

SORT_RESULT_STREAMER -- requirements
Module: sort_result_streamer

Interface
REQ-001 SHALL have parameter NUM_INPUT, default 8, meaning elements per sorted vector (power of two, >=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning bits per element.
REQ-003 SHALL have parameter LSB_FIRST, default 1, meaning 1 = emit element 0 first, 0 = emit element NUM_INPUT-1 first.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sort_data  input  NUM_INPUT*DATA_WIDTH  sorter result; element k = bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
REQ-007 SHALL have port sort_done  input  1  sorter completion, level-held while the result is valid.
REQ-008 SHALL have port in_ready  output  1  block accepts a new vector this cycle.
REQ-009 SHALL have port m_data  output  DATA_WIDTH  current streamed element.
REQ-010 SHALL have port m_valid  output  1  m_data valid.
REQ-011 SHALL have port m_ready  input  1  downstream accepts the current element.
REQ-012 SHALL have port m_last  output  1  current element is the final one of the vector.
REQ-013 SHALL have port m_index  output  $clog2(NUM_INPUT)  stream position of the current element (0 = first emitted).
REQ-014 SHALL have port overrun  output  1  sticky: a vector was dropped.

Function
REQ-015 SHALL register sort_done into done_q; capture event = sort_done & ~done_q (rising edge); a level-held sort_done SHALL cause exactly one capture.
REQ-016 SHALL implement states IDLE and STREAM.
REQ-017 IDLE: m_valid=0; in_ready=1; on a capture event SHALL load the entire sort_data into an internal buffer, set index=0, go to STREAM.
REQ-018 Latency: capture event in cycle N -> m_valid=1 with the first element in cycle N+1.
REQ-019 STREAM: m_valid=1; m_data = buffer element index (LSB_FIRST=1) or element NUM_INPUT-1-index (LSB_FIRST=0); m_index=index; m_last=(index==NUM_INPUT-1).
REQ-020 Handshake: transfer occurs iff m_valid & m_ready; on transfer with m_last=0, index increments by 1.
REQ-021 While m_valid=1 and m_ready=0, m_data, m_index, m_last SHALL remain stable; m_valid SHALL NOT drop before transfer.
REQ-022 On transfer with m_last=1 and no capture event: go to IDLE, m_valid=0 next cycle.
REQ-023 in_ready SHALL be combinational: 1 in IDLE, or in STREAM when m_last & m_ready; 0 otherwise.
REQ-024 Capture event in the same cycle as the final transfer SHALL load the new vector, reset index to 0, remain in STREAM (back-to-back, no bubble); overrun unchanged.
REQ-025 Capture event in STREAM when in_ready=0 SHALL be ignored (buffer unchanged) and SHALL set overrun=1.
REQ-026 The buffer SHALL be written only on an accepted capture; sort_data changes at other times SHALL NOT affect m_data.
REQ-027 overrun SHALL stay 1 until reset.

Reset
REQ-028 reset=1 SHALL force next cycle: state=IDLE, m_valid=0, m_last=0, m_index=0, m_data=0, overrun=0, done_q=0, buffer=0; reset overrides any simultaneous capture or transfer.
REQ-029 Reset mid-stream SHALL abandon the vector; no further elements of it are emitted.
REQ-030 sort_done already high in the first cycle after reset deasserts SHALL count as a capture event.

Verification (NUM_INPUT=4, DATA_WIDTH=8, LSB_FIRST=1 unless stated)
REQ-031 sort_data=32'h40302010, sort_done pulsed at cycle N, m_ready=1 -> m_data 10,20,30,40 in cycles N+1..N+4, m_index 0..3, m_last only at N+4, m_valid=0 at N+5.
REQ-032 Same vector, m_ready=0 for 3 cycles at index 1 -> m_data held at 20, m_valid=1 throughout, then 30,40 follow; sort_done held high 10 cycles -> exactly one vector emitted.
REQ-033 LSB_FIRST=0, sort_data=32'h40302010 -> m_data 40,30,20,10.
REQ-034 New capture event (32'hD0C0B0A0) coincident with the final transfer of 40 -> next cycle m_data=A0, m_index=0, no m_valid gap, overrun=0; capture event at index 1 instead -> ignored, overrun=1 until reset.
REQ-035 reset asserted at index 2 -> next cycle m_valid=0, m_index=0, overrun=0; no further elements of the old vector after reset releases.

Source files
------------

// File: rtl/sort_result_streamer.sv
// Streams a captured sorter result vector one element per accepted handshake.
// A rising edge of sort_done captures the vector; captures that cannot be accepted set overrun.
module sort_result_streamer #(
  parameter int NUM_INPUT  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LSB_FIRST  = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_INPUT*DATA_WIDTH-1:0] sort_data,
  input  logic                            sort_done,
  output logic                            in_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            m_last,
  output logic [$clog2(NUM_INPUT)-1:0]    m_index,
  output logic                            overrun
);

  localparam int IW = $clog2(NUM_INPUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_INPUT - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state;
  state_t                state_next;
  logic                  done_q;
  logic [IW-1:0]         index;
  logic [IW-1:0]         index_next;
  logic [IW-1:0]         sel;
  logic [DATA_WIDTH-1:0] buf_mem [NUM_INPUT];
  logic                  capture;
  logic                  transfer;
  logic                  accept;
  logic                  load;
  logic                  drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      done_q  <= 1'b0;
      index   <= '0;
      overrun <= 1'b0;
      buf_mem <= '{default: '0};
    end else begin
      state  <= state_next;
      done_q <= sort_done;
      index  <= index_next;
      if (drop)
        overrun <= 1'b1;
      if (load)
        for (int unsigned k = 0; k < NUM_INPUT; k++)
          buf_mem[k] <= sort_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    capture  = sort_done & ~done_q;
    m_valid  = (state == STREAM);
    m_last   = m_valid && (index == LAST_IDX);
    m_index  = index;
    in_ready = (state == IDLE) || (m_last && m_ready);
    transfer = m_valid & m_ready;
    accept   = capture & in_ready;

    state_next = state;
    index_next = index;
    load       = 1'b0;
    drop       = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_next = STREAM;
          index_next = '0;
          load       = 1'b1;
        end
      end
      STREAM: begin
        // A capture on the final transfer reloads in place so the stream has no bubble.
        if (accept) begin
          index_next = '0;
          load       = 1'b1;
        end else if (transfer && m_last) begin
          state_next = IDLE;
          index_next = '0;
        end else if (transfer) begin
          index_next = index + 1'b1;
        end
        if (capture && !in_ready)
          drop = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    sel    = (LSB_FIRST != 0) ? index : (LAST_IDX - index);
    m_data = buf_mem[sel];
  end

endmodule

// File: tb/tb_sort_result_streamer.sv
// Scoreboard bench for sort_result_streamer: one LSB-first and one MSB-first instance share stimulus.
module tb_sort_result_streamer;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] i;
    logic       l;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] sort_data;
  logic        sort_done;
  logic        m_ready;

  logic        in_ready_a, m_valid_a, m_last_a, overrun_a;
  logic [7:0]  m_data_a;
  logic [1:0]  m_index_a;
  logic        in_ready_b, m_valid_b, m_last_b, overrun_b;
  logic [7:0]  m_data_b;
  logic [1:0]  m_index_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   bad   = 0;

  sort_result_streamer #(.NUM_INPUT(4), .DATA_WIDTH(8), .LSB_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .sort_data(sort_data), .sort_done(sort_done),
    .in_ready(in_ready_a), .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready),
    .m_last(m_last_a), .m_index(m_index_a), .overrun(overrun_a)
  );

  sort_result_streamer #(.NUM_INPUT(4), .DATA_WIDTH(8), .LSB_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .sort_data(sort_data), .sort_done(sort_done),
    .in_ready(in_ready_b), .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready),
    .m_last(m_last_b), .m_index(m_index_b), .overrun(overrun_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every handshake on either instance pops one expected element.
  always @(negedge clk) begin
    if (!reset && m_valid_a && m_ready) begin
      total++;
      if (q_a.size() == 0) begin
        bad++;
        $display("FAIL lsb_unexpected: got data=%h idx=%0d last=%b, required none", m_data_a, m_index_a, m_last_a);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        if ({m_data_a, m_index_a, m_last_a} !== e) begin
          bad++;
          $display("FAIL lsb_stream: got data=%h idx=%0d last=%b, required data=%h idx=%0d last=%b",
                   m_data_a, m_index_a, m_last_a, e.d, e.i, e.l);
        end
      end
    end
    if (!reset && m_valid_b && m_ready) begin
      total++;
      if (q_b.size() == 0) begin
        bad++;
        $display("FAIL msb_unexpected: got data=%h idx=%0d last=%b, required none", m_data_b, m_index_b, m_last_b);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        if ({m_data_b, m_index_b, m_last_b} !== e) begin
          bad++;
          $display("FAIL msb_stream: got data=%h idx=%0d last=%b, required data=%h idx=%0d last=%b",
                   m_data_b, m_index_b, m_last_b, e.d, e.i, e.l);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input logic [31:0] v);
    for (int unsigned k = 0; k < 4; k++) begin
      q_a.push_back({v[8*k +: 8], 2'(k), (k == 3)});
      q_b.push_back({v[8*(3-k) +: 8], 2'(k), (k == 3)});
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (m_valid_a && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (m_valid_a !== 1'b0 || q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got valid=%b pending=%0d/%0d, required valid=0 pending=0/0",
               name, m_valid_a, q_a.size(), q_b.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sort_done = 1'b0; m_ready = 1'b1; sort_data = 32'h0;
    tick(); tick();
    total++;
    if ({m_valid_a, m_last_a, m_index_a, m_data_a, overrun_a, in_ready_a} !== {1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: got valid=%b last=%b idx=%0d data=%h ovr=%b rdy=%b, required 0 0 0 00 0 1",
               m_valid_a, m_last_a, m_index_a, m_data_a, overrun_a, in_ready_a);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    sort_data = 32'h40302010; sort_done = 1'b1; m_ready = 1'b1;
    push_vec(32'h40302010);
    tick();
    sort_done = 1'b0;
    total++;
    if ({m_valid_a, m_data_a, m_data_b, in_ready_a} !== {1'b1, 8'h10, 8'h40, 1'b0}) begin
      bad++;
      $display("FAIL basic_latency: got valid=%b lsb=%h msb=%h rdy=%b, required 1 10 40 0",
               m_valid_a, m_data_a, m_data_b, in_ready_a);
    end
    tick(); tick(); tick();
    total++;
    if ({m_last_a, in_ready_a} !== 2'b11) begin
      bad++;
      $display("FAIL basic_last: got last=%b rdy=%b, required 1 1", m_last_a, in_ready_a);
    end
    tick();
    total++;
    if (m_valid_a !== 1'b0) begin
      bad++;
      $display("FAIL basic_end: got valid=%b, required 0", m_valid_a);
    end
    drain("basic");
  endtask

  task automatic test_stall();
    sort_data = 32'h40302010; sort_done = 1'b1; m_ready = 1'b1;
    push_vec(32'h40302010);
    tick(); tick();
    m_ready = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({m_valid_a, m_data_a, m_index_a, m_last_a, m_data_b} !== {1'b1, 8'h20, 2'd1, 1'b0, 8'h30}) begin
        bad++;
        $display("FAIL stall_hold: got valid=%b lsb=%h idx=%0d last=%b msb=%h, required 1 20 1 0 30",
                 m_valid_a, m_data_a, m_index_a, m_last_a, m_data_b);
      end
    end
    m_ready = 1'b1;
    for (int unsigned c = 0; c < 5; c++) tick();
    sort_done = 1'b0;
    tick(); tick();
    drain("stall");
  endtask

  task automatic test_back_to_back();
    sort_data = 32'h40302010; sort_done = 1'b1; m_ready = 1'b1;
    push_vec(32'h40302010);
    tick();
    sort_done = 1'b0;
    tick(); tick(); tick();
    sort_data = 32'hD0C0B0A0; sort_done = 1'b1;
    push_vec(32'hD0C0B0A0);
    #1;
    total++;
    if ({m_last_a, in_ready_a} !== 2'b11) begin
      bad++;
      $display("FAIL b2b_ready: got last=%b rdy=%b, required 1 1", m_last_a, in_ready_a);
    end
    tick();
    sort_done = 1'b0;
    total++;
    if ({m_valid_a, m_data_a, m_index_a, overrun_a, m_data_b} !== {1'b1, 8'hA0, 2'd0, 1'b0, 8'hD0}) begin
      bad++;
      $display("FAIL b2b_reload: got valid=%b lsb=%h idx=%0d ovr=%b msb=%h, required 1 a0 0 0 d0",
               m_valid_a, m_data_a, m_index_a, overrun_a, m_data_b);
    end
    drain("b2b");
  endtask

  task automatic test_overrun();
    sort_data = 32'h40302010; sort_done = 1'b1; m_ready = 1'b1;
    push_vec(32'h40302010);
    tick();
    sort_done = 1'b0;
    tick();
    sort_data = 32'hFFEEDDCC; sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
    total++;
    if ({overrun_a, overrun_b, m_data_a, m_index_a} !== {1'b1, 1'b1, 8'h30, 2'd2}) begin
      bad++;
      $display("FAIL overrun_set: got ovr=%b/%b data=%h idx=%0d, required 1/1 30 2",
               overrun_a, overrun_b, m_data_a, m_index_a);
    end
    drain("overrun");
    tick(); tick();
    total++;
    if (overrun_a !== 1'b1) begin
      bad++;
      $display("FAIL overrun_sticky: got %b, required 1", overrun_a);
    end
  endtask

  task automatic test_reset_mid();
    sort_data = 32'h40302010; sort_done = 1'b1; m_ready = 1'b1;
    push_vec(32'h40302010);
    tick();
    sort_done = 1'b0;
    tick(); tick();
    total++;
    if (m_index_a !== 2'd2) begin
      bad++;
      $display("FAIL midreset_pos: got idx=%0d, required 2", m_index_a);
    end
    reset = 1'b1;
    q_a.delete();
    q_b.delete();
    tick();
    total++;
    if ({m_valid_a, m_index_a, overrun_a} !== {1'b0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL midreset_state: got valid=%b idx=%0d ovr=%b, required 0 0 0",
               m_valid_a, m_index_a, overrun_a);
    end
    reset = 1'b0;
    for (int unsigned c = 0; c < 6; c++) begin
      tick();
      total++;
      if (m_valid_a !== 1'b0 || m_valid_b !== 1'b0) begin
        bad++;
        $display("FAIL midreset_quiet: got valid=%b/%b, required 0/0", m_valid_a, m_valid_b);
      end
    end
  endtask

  task automatic test_done_over_reset();
    reset = 1'b1; sort_data = 32'h04030201; sort_done = 1'b1; m_ready = 1'b1;
    tick();
    reset = 1'b0;
    push_vec(32'h04030201);
    tick();
    total++;
    if ({m_valid_a, m_data_a} !== {1'b1, 8'h01}) begin
      bad++;
      $display("FAIL held_done_capture: got valid=%b data=%h, required 1 01", m_valid_a, m_data_a);
    end
    for (int unsigned c = 0; c < 6; c++) tick();
    sort_done = 1'b0;
    drain("held");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_done_over_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "timeout");
  end

endmodule
